// File: rtl/msrv32_ahb_port_arbiter.sv
// Shares one AHB-Lite master port between instruction fetch and data access.
// Data normally wins; a saturating streak counter lets a waiting fetch through.
module msrv32_ahb_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              i_req_in,
    input  logic [ADDR_W-1:0] i_addr_in,
    output logic              i_ack_out,
    output logic [DATA_W-1:0] i_rdata_out,
    output logic              i_err_out,
    input  logic              d_req_in,
    input  logic              d_wr_in,
    input  logic [ADDR_W-1:0] d_addr_in,
    input  logic [DATA_W-1:0] d_wdata_in,
    input  logic [3:0]        d_mask_in,
    output logic              d_ack_out,
    output logic [DATA_W-1:0] d_rdata_out,
    output logic              d_err_out,
    output logic [ADDR_W-1:0] ahb_haddr_out,
    output logic [1:0]        ahb_htrans_out,
    output logic              ahb_hwrite_out,
    output logic [2:0]        ahb_hsize_out,
    output logic [DATA_W-1:0] ahb_hwdata_out,
    output logic [3:0]        ahb_wmask_out,
    input  logic [DATA_W-1:0] ahb_hrdata_in,
    input  logic              ahb_hready_in,
    input  logic              ahb_hresp_in
);

    localparam int            SW            = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX    = SW'(STARVE_MAX);
    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t              state_q,   state_d;
    logic [SW-1:0]       streak_q,  streak_d;
    logic                dgrant_q,  dgrant_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [3:0]          mask_q,    mask_d;
    logic [ADDR_W-1:0]   haddr_q,   haddr_d;
    logic [1:0]          htrans_q,  htrans_d;
    logic                hwrite_q,  hwrite_d;
    logic [DATA_W-1:0]   hwdata_q,  hwdata_d;
    logic [3:0]          wmask_q,   wmask_d;
    logic                i_ack_q,   i_ack_d;
    logic                d_ack_q,   d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_err_q,   i_err_d;
    logic                d_err_q,   d_err_d;

    logic fetch_starved;
    assign fetch_starved = i_req_in && (streak_q == STREAK_MAX);

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            dgrant_q  <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= '0;
            haddr_q   <= '0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            wmask_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            dgrant_q  <= dgrant_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            wmask_q   <= wmask_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
        end
    end

    // Response outputs default low so ack/err/rdata only show during RESP.
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        dgrant_d  = dgrant_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwrite_d  = hwrite_q;
        hwdata_d  = hwdata_q;
        wmask_d   = wmask_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = '0;
        d_rdata_d = '0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!i_req_in) begin
                    streak_d = '0;
                end
                if (d_req_in && !fetch_starved) begin
                    dgrant_d = 1'b1;
                    haddr_d  = d_addr_in;
                    hwrite_d = d_wr_in;
                    wdata_d  = d_wr_in ? d_wdata_in : '0;
                    mask_d   = d_wr_in ? d_mask_in : 4'b0000;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ADDR;
                    if (i_req_in && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_req_in) begin
                    dgrant_d = 1'b0;
                    haddr_d  = i_addr_in;
                    hwrite_d = 1'b0;
                    wdata_d  = '0;
                    mask_d   = 4'b0000;
                    htrans_d = HTRANS_NONSEQ;
                    streak_d = '0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (ahb_hready_in) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                    wmask_d  = hwrite_q ? mask_q : 4'b0000;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (ahb_hready_in) begin
                    if (dgrant_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = ahb_hrdata_in;
                        d_err_d   = ahb_hresp_in;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = ahb_hrdata_in;
                        i_err_d   = ahb_hresp_in;
                    end
                    hwrite_d = 1'b0;
                    hwdata_d = '0;
                    wmask_d  = 4'b0000;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_ack_out      = i_ack_q;
    assign i_rdata_out    = i_rdata_q;
    assign i_err_out      = i_err_q;
    assign d_ack_out      = d_ack_q;
    assign d_rdata_out    = d_rdata_q;
    assign d_err_out      = d_err_q;
    assign ahb_haddr_out  = haddr_q;
    assign ahb_htrans_out = htrans_q;
    assign ahb_hwrite_out = hwrite_q;
    assign ahb_hsize_out  = 3'b010;
    assign ahb_hwdata_out = hwdata_q;
    assign ahb_wmask_out  = wmask_q;

endmodule

// File: tb/tb_msrv32_ahb_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked against
// a transaction-level arbitration/timing model.
module tb_msrv32_ahb_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_mask = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [3:0]  wmask;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b0;
    logic        hresp = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int m_streak = 0;

    msrv32_ahb_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst_n),
        .i_req_in(i_req),
        .i_addr_in(i_addr),
        .i_ack_out(i_ack),
        .i_rdata_out(i_rdata),
        .i_err_out(i_err),
        .d_req_in(d_req),
        .d_wr_in(d_wr),
        .d_addr_in(d_addr),
        .d_wdata_in(d_wdata),
        .d_mask_in(d_mask),
        .d_ack_out(d_ack),
        .d_rdata_out(d_rdata),
        .d_err_out(d_err),
        .ahb_haddr_out(haddr),
        .ahb_htrans_out(htrans),
        .ahb_hwrite_out(hwrite),
        .ahb_hsize_out(hsize),
        .ahb_hwdata_out(hwdata),
        .ahb_wmask_out(wmask),
        .ahb_hrdata_in(hrdata),
        .ahb_hready_in(hready),
        .ahb_hresp_in(hresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rules: data wins unless fetch also waits and the streak is full.
    task automatic model_arbitrate(input bit ir, input bit dr, output bit dwin);
        dwin = dr && !(ir && (m_streak == STARVE_MAX));
        if (dwin && ir) m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
        else            m_streak = 0;
    endtask

    task automatic idle_cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        m_streak = 0;
        tick();
        n_checks++; if (htrans !== 2'b00) $display("[TB] FAIL idle_htrans: got %b want 00", htrans); else n_pass++;
        n_checks++; if ({i_ack, d_ack} !== 2'b00) $display("[TB] FAIL idle_acks: got %b want 00", {i_ack, d_ack}); else n_pass++;
    endtask

    // Called in the IDLE cycle where requests are already driven; returns in the next IDLE cycle.
    task automatic run_transfer(input bit exp_d, input int wa, input int wd, input logic [31:0] rd, input bit rsp);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ew;
        logic [3:0]  em;
        ea  = exp_d ? d_addr : i_addr;
        ew  = exp_d & d_wr;
        ewd = d_wdata;
        em  = ew ? d_mask : 4'b0000;
        tick();
        for (int k = 0; k <= wa; k++) begin
            n_checks++; if (htrans !== 2'b10) $display("[TB] FAIL addr_htrans: got %b want 10", htrans); else n_pass++;
            n_checks++; if (haddr !== ea) $display("[TB] FAIL addr_haddr: got %h want %h", haddr, ea); else n_pass++;
            n_checks++; if (hwrite !== ew) $display("[TB] FAIL addr_hwrite: got %b want %b", hwrite, ew); else n_pass++;
            n_checks++; if (hsize !== 3'b010) $display("[TB] FAIL addr_hsize: got %b want 010", hsize); else n_pass++;
            n_checks++; if ({i_ack, d_ack} !== 2'b00) $display("[TB] FAIL addr_acks: got %b want 00", {i_ack, d_ack}); else n_pass++;
            hready = (k == wa);
            hresp  = 1'($urandom);
            hrdata = $urandom;
            tick();
        end
        for (int k = 0; k <= wd; k++) begin
            n_checks++; if (htrans !== 2'b00) $display("[TB] FAIL data_htrans: got %b want 00", htrans); else n_pass++;
            n_checks++; if (wmask !== em) $display("[TB] FAIL data_wmask: got %b want %b", wmask, em); else n_pass++;
            if (ew) begin
                n_checks++; if (hwdata !== ewd) $display("[TB] FAIL data_hwdata: got %h want %h", hwdata, ewd); else n_pass++;
            end
            n_checks++; if ({i_ack, d_ack} !== 2'b00) $display("[TB] FAIL data_acks: got %b want 00", {i_ack, d_ack}); else n_pass++;
            hready = (k == wd);
            hresp  = (k == wd) ? rsp : (rsp | 1'($urandom));
            hrdata = (k == wd) ? rd : $urandom;
            tick();
        end
        hready = 1'($urandom);
        hresp  = 1'($urandom);
        hrdata = $urandom;
        n_checks++; if (d_ack !== exp_d) $display("[TB] FAIL resp_d_ack: got %b want %b", d_ack, exp_d); else n_pass++;
        n_checks++; if (i_ack !== !exp_d) $display("[TB] FAIL resp_i_ack: got %b want %b", i_ack, !exp_d); else n_pass++;
        n_checks++; if ((exp_d ? d_err : i_err) !== rsp) $display("[TB] FAIL resp_err: got %b want %b", exp_d ? d_err : i_err, rsp); else n_pass++;
        n_checks++; if ((exp_d ? i_err : d_err) !== 1'b0) $display("[TB] FAIL resp_other_err: got %b want 0", exp_d ? i_err : d_err); else n_pass++;
        if (!rsp) begin
            n_checks++; if ((exp_d ? d_rdata : i_rdata) !== rd) $display("[TB] FAIL resp_rdata: got %h want %h", exp_d ? d_rdata : i_rdata, rd); else n_pass++;
        end
        tick();
        n_checks++; if ({i_ack, d_ack} !== 2'b00) $display("[TB] FAIL post_acks: got %b want 00", {i_ack, d_ack}); else n_pass++;
        n_checks++; if (htrans !== 2'b00) $display("[TB] FAIL post_htrans: got %b want 00", htrans); else n_pass++;
    endtask

    task automatic test_reset();
        d_req = 1'b1;
        i_req = 1'b1;
        hready = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (htrans !== 2'b00) $display("[TB] FAIL rst_htrans: got %b want 00", htrans); else n_pass++;
        n_checks++; if (haddr !== 32'h0) $display("[TB] FAIL rst_haddr: got %h want 0", haddr); else n_pass++;
        n_checks++; if (hwrite !== 1'b0) $display("[TB] FAIL rst_hwrite: got %b want 0", hwrite); else n_pass++;
        n_checks++; if (hwdata !== 32'h0) $display("[TB] FAIL rst_hwdata: got %h want 0", hwdata); else n_pass++;
        n_checks++; if (wmask !== 4'h0) $display("[TB] FAIL rst_wmask: got %b want 0000", wmask); else n_pass++;
        n_checks++; if (hsize !== 3'b010) $display("[TB] FAIL rst_hsize: got %b want 010", hsize); else n_pass++;
        n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'h0) $display("[TB] FAIL rst_ack_err: got %b want 0000", {i_ack, d_ack, i_err, d_err}); else n_pass++;
        n_checks++; if ({i_rdata, d_rdata} !== 64'h0) $display("[TB] FAIL rst_rdata: got %h want 0", {i_rdata, d_rdata}); else n_pass++;
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;
        m_streak = 0;
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_zero_wait_read();
        bit dwin;
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h100; d_mask = 4'hF;
        model_arbitrate(1'b0, 1'b1, dwin);
        run_transfer(dwin, 0, 0, 32'hDEADBEEF, 1'b0);
        d_req = 1'b0;
    endtask

    task automatic test_write_wait();
        bit dwin;
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_mask = 4'b0011;
        model_arbitrate(1'b0, 1'b1, dwin);
        run_transfer(dwin, 0, 2, $urandom, 1'b0);
        d_req = 1'b0; d_wr = 1'b0;
    endtask

    task automatic test_error();
        bit dwin;
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
        model_arbitrate(1'b1, 1'b0, dwin);
        run_transfer(dwin, 0, 1, $urandom, 1'b1);
        i_req = 1'b0;
    endtask

    task automatic test_contention();
        logic [9:0] exp_order;
        bit         dwin;
        exp_order = 10'b1111011110;
        #3 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_streak = 0;
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_2000;
        for (int k = 0; k < 10; k++) begin
            model_arbitrate(1'b1, 1'b1, dwin);
            run_transfer(exp_order[9-k], 0, 0, $urandom, 1'b0);
        end
    endtask

    task automatic test_drop();
        bit dwin;
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_3000;
        model_arbitrate(1'b1, 1'b1, dwin);
        run_transfer(dwin, 1, 0, $urandom, 1'b0);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        bit dwin;
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5A5_5A5A; d_mask = 4'hF;
        model_arbitrate(1'b0, 1'b1, dwin);
        tick();
        hready = 1'b1;
        tick();
        hready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (htrans !== 2'b00) $display("[TB] FAIL rmid_htrans: got %b want 00", htrans); else n_pass++;
        n_checks++; if ({i_ack, d_ack} !== 2'b00) $display("[TB] FAIL rmid_acks: got %b want 00", {i_ack, d_ack}); else n_pass++;
        n_checks++; if ({wmask, hwdata} !== 36'h0) $display("[TB] FAIL rmid_wdata: got %h want 0", {wmask, hwdata}); else n_pass++;
        n_checks++; if (hsize !== 3'b010) $display("[TB] FAIL rmid_hsize: got %b want 010", hsize); else n_pass++;
        d_req = 1'b0;
        hready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        m_streak = 0;
        for (int k = 0; k < 3; k++) idle_cycle();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h400;
        model_arbitrate(1'b0, 1'b1, dwin);
        run_transfer(dwin, 0, 0, 32'hCAFEF00D, 1'b0);
        d_req = 1'b0;
    endtask

    task automatic test_random();
        bit ip;
        bit dp;
        bit dwin;
        ip = 1'b0;
        dp = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
                ip = 1'b0;
                dp = 1'b0;
            end
            if (ip && $urandom_range(0, 9) == 0) ip = 1'b0;
            if (dp && $urandom_range(0, 9) == 0) dp = 1'b0;
            if (!ip && $urandom_range(0, 9) < 6) begin
                ip = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && ($urandom_range(0, 9) < 6 || !ip)) begin
                dp = 1'b1;
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wr    = 1'($urandom);
                d_wdata = $urandom;
                d_mask  = 4'($urandom);
            end
            i_req = ip;
            d_req = dp;
            model_arbitrate(ip, dp, dwin);
            run_transfer(dwin, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, ($urandom_range(0, 3) == 0));
            if (dwin) dp = 1'b0;
            else      ip = 1'b0;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_error();
        test_contention();
        test_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/msrv32_ahb_port_arbiter.md
MSRV32_AHB_PORT_ARBITER -- requirements
Module: msrv32_ahb_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_MAX, 4, consecutive data grants allowed while instruction fetch waits.
REQ-002 SHALL have ports, clock and reset first:
- ms_riscv32_mp_clk_in  in  1  sole clock; all state updates on its rising edge.
- ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-low.
- i_req_in  in  1  instruction fetch request.
- i_addr_in  in  ADDR_W  fetch address.
- i_ack_out  out  1  fetch complete, 1-cycle pulse.
- i_rdata_out  out  DATA_W  fetched word, valid with i_ack_out.
- i_err_out  out  1  fetch bus error, valid with i_ack_out.
- d_req_in  in  1  data request.
- d_wr_in  in  1  1 = write, 0 = read.
- d_addr_in  in  ADDR_W  data address.
- d_wdata_in  in  DATA_W  write data.
- d_mask_in  in  4  byte write mask.
- d_ack_out  out  1  data complete, 1-cycle pulse.
- d_rdata_out  out  DATA_W  read data, valid with d_ack_out.
- d_err_out  out  1  data bus error, valid with d_ack_out.
- ahb_haddr_out  out  ADDR_W  AHB address.
- ahb_htrans_out  out  2  2'b10 NONSEQ or 2'b00 IDLE only.
- ahb_hwrite_out  out  1  AHB write.
- ahb_hsize_out  out  3  constant 3'b010.
- ahb_hwdata_out  out  DATA_W  AHB write data.
- ahb_wmask_out  out  4  byte mask; 4'b0000 for reads and fetches.
- ahb_hrdata_in  in  DATA_W  AHB read data.
- ahb_hready_in  in  1  AHB ready.
- ahb_hresp_in  in  1  AHB error response.

Function
REQ-003 SHALL implement the FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; only one transfer outstanding; all outputs registered.
REQ-004 IDLE: if any request is present, SHALL latch the winner's address, direction, data and mask, and SHALL move to ADDR. With no request, it SHALL stay in IDLE.
REQ-005 Arbitration: data wins over fetch, except when both request and the streak counter equals STARVE_MAX; then fetch SHALL win.
REQ-006 Streak counter: +1 on a data grant while i_req_in=1, saturating at STARVE_MAX. It SHALL clear on a fetch grant and in any IDLE cycle with i_req_in=0.
REQ-007 ADDR: htrans=NONSEQ, haddr and hwrite driven. It SHALL stay in ADDR while ahb_hready_in=0, with the address held stable. It SHALL go to DATA on ahb_hready_in=1.
REQ-008 DATA: htrans=IDLE. For writes, hwdata and wmask SHALL be driven. It SHALL wait while ahb_hready_in=0. On ahb_hready_in=1 it SHALL capture ahb_hrdata_in and ahb_hresp_in and go to RESP.
REQ-009 Error: ahb_hresp_in=1 with ahb_hready_in=0 SHALL be treated as a wait state. The hresp value at the completing cycle SHALL set err_out; read data is then don't-care.
REQ-010 RESP: the granted requester's ack_out=1 for exactly one cycle, together with rdata_out and err_out; then IDLE. Requests sampled in RESP SHALL be ignored.
REQ-011 Requesters SHALL hold request fields stable from request until ack. A request deasserted before grant SHALL be dropped without bus activity.
REQ-012 Minimum latency: request in IDLE cycle N -> NONSEQ in N+1 -> data phase N+2 -> ack in N+3; one transfer per 4 cycles at best.
REQ-013 At most one ack_out SHALL be high in any cycle; the non-granted requester's ack and err SHALL stay 0.

Reset
REQ-014 Reset assertion SHALL immediately force IDLE, streak=0 and all outputs 0, including htrans=IDLE; hsize stays 3'b010.
REQ-015 Reset mid-transfer SHALL abandon the transfer with no ack; after release, the first sampled request starts a fresh transfer.

Verification
REQ-016 Zero-wait read: d_req, addr 0x100, hrdata 0xDEADBEEF -> NONSEQ@0x100 in cycle 1, d_ack=1 and d_rdata=0xDEADBEEF in cycle 3.
REQ-017 Write with 2 wait states: addr 0x200, wdata 0x12345678, mask 4'b0011 -> hwrite=1, hwdata and mask held through 3 DATA cycles, d_ack in the following cycle.
REQ-018 Contention: both request continuously -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-019 Error: fetch at 0x0, bus gives hresp=1/hready=0 then hresp=1/hready=1 -> i_ack=1 and i_err=1 for one cycle, d_ack=0.
REQ-020 Reset asserted in DATA -> htrans=00 and all acks 0 immediately; no ack after release; a new request completes normally.
